fetch_unit: RTL

Instruction fetch controller for the RISC-V core. Holds the fetch program counter, issues one instruction-memory request at a time with a request/grant handshake, and buffers the returned word for decode. It consumes the redirect target produced by the branch/jump target adder, squashing any in-flight fetch. All requests and responses are single-beat, with at most one outstanding request.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_unit_inst_buffer.sv | 37 +++
 rtl/fetch_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        FETCH_REQ   = 3'd0,
        FETCH_WAIT  = 3'd1,
        FETCH_FLUSH = 3'd2,
        FETCH_HOLD  = 3'd3,
        FETCH_FAULT = 3'd4
    } fetchState_e;

    localparam logic [31:0] INST_BYTES = 32'd4;

    // Instructions are word aligned; any low address bit set is a fault.
    function automatic logic isMisaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_inst_buffer.sv
// One-entry holding register for the fetched instruction and its address.
module fetch_unit_inst_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] pc_q;

    // Clear only drops the valid flag; the word itself is kept until overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= 32'h0;
            pc_q    <= 32'h0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: one outstanding single-beat request,
// redirect squashing, and a sticky fault on misaligned redirect targets.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirectValid,
    input  logic [31:0] targetAddr,
    input  logic        stall,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic        instValid,
    output logic [31:0] inst,
    output logic [31:0] PC,
    output logic        misalignFault
);

    fetchState_e state_q, state_d;
    logic [31:0] fetchPc_q, fetchPc_d;
    logic [31:0] reqPc_q, reqPc_d;
    logic        misalign_q, misalign_d;
    logic        bufLoad;
    logic        bufClear;
    logic        badRedirect;

    // State, fetch address, in-flight request address and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH_REQ;
            fetchPc_q  <= RESET_PC;
            reqPc_q    <= 32'h0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetchPc_q  <= fetchPc_d;
            reqPc_q    <= reqPc_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic; a misaligned redirect overrides every other event.
    always_comb begin
        state_d     = state_q;
        fetchPc_d   = fetchPc_q;
        reqPc_d     = reqPc_q;
        misalign_d  = misalign_q;
        bufLoad     = 1'b0;
        bufClear    = 1'b0;
        badRedirect = redirectValid && isMisaligned(targetAddr);

        if (state_q != FETCH_FAULT && badRedirect) begin
            state_d    = FETCH_FAULT;
            misalign_d = 1'b1;
            bufClear   = 1'b1;
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (redirectValid) begin
                        fetchPc_d = targetAddr;
                        if (imemGnt) state_d = FETCH_FLUSH;
                    end else if (imemGnt) begin
                        reqPc_d = fetchPc_q;
                        state_d = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (redirectValid) begin
                        fetchPc_d = targetAddr;
                        state_d   = imemRvalid ? FETCH_REQ : FETCH_FLUSH;
                    end else if (imemRvalid) begin
                        bufLoad   = 1'b1;
                        fetchPc_d = reqPc_q + INST_BYTES;
                        state_d   = FETCH_HOLD;
                    end
                end
                FETCH_FLUSH: begin
                    if (redirectValid) fetchPc_d = targetAddr;
                    if (imemRvalid) state_d = FETCH_REQ;
                end
                FETCH_HOLD: begin
                    if (redirectValid) begin
                        fetchPc_d = targetAddr;
                        bufClear  = 1'b1;
                        state_d   = FETCH_REQ;
                    end else if (!stall) begin
                        bufClear = 1'b1;
                        state_d  = FETCH_REQ;
                    end
                end
                FETCH_FAULT: begin
                    bufClear = 1'b1;
                end
                default: begin
                    state_d = FETCH_REQ;
                end
            endcase
        end
    end

    fetch_unit_inst_buffer u_instBuffer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (bufLoad),
        .clear_i (bufClear),
        .inst_i  (imemRdata),
        .pc_i    (reqPc_q),
        .valid_o (instValid),
        .inst_o  (inst),
        .pc_o    (PC)
    );

    assign imemReq       = (state_q == FETCH_REQ) && !rst;
    assign imemAddr      = fetchPc_q;
    assign misalignFault = misalign_q;

endmodule
